// File: rtl/calc_seq_ctrl.sv
// Pair-sum sequencer: reads word pairs from a single-port SRAM, adds them, writes sums sequentially.
// Four cycles per pair (read A, read B, add, write); done pulses one cycle after the last write.
package calculator_pkg;
    parameter int DATA_W = 32;
endpackage

module adder32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);
    assign sum_o = a_i + b_i;
endmodule

module calc_seq_ctrl #(
    parameter int DATA_W = calculator_pkg::DATA_W,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] read_start_addr_i,
    input  logic [ADDR_W-1:0] read_end_addr_i,
    input  logic [ADDR_W-1:0] write_start_addr_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] pairs_o
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ_A = 3'd1,
        READ_B = 3'd2,
        ADD    = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_end;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [ADDR_W-1:0]   r_pairs;
    logic [DATA_W-1:0]   w_sum;
    logic                w_range_ok;
    logic                w_more;

    adder32 #(.W(DATA_W)) u_adder (
        .a_i   (r_op_a),
        .b_i   (r_op_b),
        .sum_o (w_sum)
    );

    // Extra MSB keeps the range compares from wrapping at the top of the address space.
    assign w_range_ok = ({1'b0, read_end_addr_i} >= ({1'b0, read_start_addr_i} + (ADDR_W+1)'(1)));
    assign w_more     = (({1'b0, r_rd_ptr} + (ADDR_W+1)'(3)) <= {1'b0, r_end});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        busy_o      = (r_state != IDLE);
        done_o      = (r_state == DONE);
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next = w_range_ok ? READ_A : DONE;
                end
            end
            READ_A: begin
                mem_req_o  = 1'b1;
                mem_addr_o = r_rd_ptr;
                w_next     = READ_B;
            end
            READ_B: begin
                mem_req_o  = 1'b1;
                mem_addr_o = r_rd_ptr + ADDR_W'(1);
                w_next     = ADD;
            end
            ADD: begin
                w_next = WRITE;
            end
            WRITE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = r_wr_ptr;
                mem_wdata_o = w_sum;
                w_next      = w_more ? READ_A : DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_end    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_pairs  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_rd_ptr <= read_start_addr_i;
                        r_wr_ptr <= write_start_addr_i;
                        r_end    <= read_end_addr_i;
                        r_pairs  <= '0;
                    end
                end
                READ_B: r_op_a <= mem_rdata_i;
                ADD:    r_op_b <= mem_rdata_i;
                WRITE: begin
                    r_rd_ptr <= r_rd_ptr + ADDR_W'(2);
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                    r_pairs  <= r_pairs + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign pairs_o = r_pairs;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: SRAM model plus a per-cycle schedule derived from the pair/timing rules.
module tb_calc_seq_ctrl;
    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic [9:0]  read_start_addr_i;
    logic [9:0]  read_end_addr_i;
    logic [9:0]  write_start_addr_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        busy_o;
    logic        done_o;
    logic [9:0]  pairs_o;

    int checks;
    int errors;

    logic [31:0] mem [1024];
    bit          read_hit [1024];

    calc_seq_ctrl #(.DATA_W(32), .ADDR_W(10)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .start_i            (start_i),
        .read_start_addr_i  (read_start_addr_i),
        .read_end_addr_i    (read_end_addr_i),
        .write_start_addr_i (write_start_addr_i),
        .mem_req_o          (mem_req_o),
        .mem_we_o           (mem_we_o),
        .mem_addr_o         (mem_addr_o),
        .mem_wdata_o        (mem_wdata_o),
        .mem_rdata_i        (mem_rdata_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .pairs_o            (pairs_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single-port SRAM: read data valid one cycle after the request, garbage otherwise.
    always @(posedge clk_i) begin
        if (mem_req_o && !mem_we_o) begin
            mem_rdata_i <= mem[mem_addr_o];
            read_hit[mem_addr_o] <= 1'b1;
        end else begin
            mem_rdata_i <= $urandom;
        end
        if (mem_req_o && mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
    end

    task automatic test_sequence(input logic [9:0] rs, input logic [9:0] re, input logic [9:0] ws,
                                 input int pulse_at, input bit hold,
                                 output int done_cyc, output int pairs_seen);
        int n;
        logic [31:0] exp_data [$];
        logic [9:0]  exp_waddr [$];
        logic        e_req, e_we, e_busy, e_done;
        logic [9:0]  e_addr;
        logic [31:0] e_wdata;
        int k, ph, last;
        n = (int'(re) >= int'(rs) + 1) ? (int'(re) - int'(rs) + 1) / 2 : 0;
        for (int i = 0; i < n; i++) begin
            exp_data.push_back(mem[int'(rs) + 2*i] + mem[int'(rs) + 2*i + 1]);
            exp_waddr.push_back(10'((int'(ws) + i) % 1024));
        end
        for (int i = 0; i < 1024; i++) read_hit[i] = 1'b0;
        done_cyc   = -1;
        pairs_seen = -1;
        last = 4*n + 2;
        @(negedge clk_i);
        read_start_addr_i  = rs;
        read_end_addr_i    = re;
        write_start_addr_i = ws;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        for (int c = 1; c <= last; c++) begin
            if (c == pulse_at) start_i = 1'b1;
            else if (!hold) start_i = 1'b0;
            e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
            if (c <= 4*n) begin
                k  = (c - 1) / 4;
                ph = (c - 1) % 4;
                case (ph)
                    0: begin e_req = 1; e_addr = 10'(int'(rs) + 2*k); end
                    1: begin e_req = 1; e_addr = 10'(int'(rs) + 2*k + 1); end
                    3: begin e_req = 1; e_we = 1; e_addr = exp_waddr[k]; e_wdata = exp_data[k]; end
                    default: ;
                endcase
            end
            e_busy = (c <= 4*n + 1);
            e_done = (c == 4*n + 1);
            if (done_o === 1'b1 && done_cyc < 0) done_cyc = c;
            checks++;
            if (mem_req_o !== e_req || mem_we_o !== e_we) begin
                errors++;
                $display("FAIL req_we cycle %0d: got req=%b we=%b, want req=%b we=%b", c, mem_req_o, mem_we_o, e_req, e_we);
            end
            checks++;
            if (mem_addr_o !== e_addr) begin
                errors++;
                $display("FAIL addr cycle %0d: got %h, want %h", c, mem_addr_o, e_addr);
            end
            if (!(e_req && !e_we)) begin
                checks++;
                if (mem_wdata_o !== e_wdata) begin
                    errors++;
                    $display("FAIL wdata cycle %0d: got %h, want %h", c, mem_wdata_o, e_wdata);
                end
            end
            checks++;
            if (busy_o !== e_busy || done_o !== e_done) begin
                errors++;
                $display("FAIL busy_done cycle %0d: got busy=%b done=%b, want busy=%b done=%b", c, busy_o, done_o, e_busy, e_done);
            end
            if (c == last) begin
                pairs_seen = int'(pairs_o);
                checks++;
                if (pairs_o !== 10'(n)) begin
                    errors++;
                    $display("FAIL pairs_o: got %0d, want %0d", pairs_o, n);
                end
            end else begin
                @(posedge clk_i); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        start_i = 1'b0;
        read_start_addr_i = '0; read_end_addr_i = '0; write_start_addr_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, pairs_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h busy=%b done=%b pairs=%0d, want all 0",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, pairs_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b req=%b, want 0 0", busy_o, mem_req_o);
        end
    endtask

    task automatic test_basic();
        int dc, pr;
        mem[0] = 32'd5; mem[1] = 32'd7; mem[16] = 32'hDEAD_BEEF;
        test_sequence(10'd0, 10'd1, 10'd16, 0, 0, dc, pr);
        checks++;
        if (mem[16] !== 32'd12 || dc !== 5 || pr !== 1) begin
            errors++;
            $display("FAIL basic: got mem16=%0d done_cyc=%0d pairs=%0d, want 12 5 1", mem[16], dc, pr);
        end
    endtask

    task automatic test_multi_pair();
        int dc, pr;
        for (int i = 0; i < 6; i++) mem[i] = 32'(i + 1);
        test_sequence(10'd0, 10'd5, 10'd8, 0, 0, dc, pr);
        checks++;
        if (mem[8] !== 32'd3 || mem[9] !== 32'd7 || mem[10] !== 32'd11 || dc !== 13 || pr !== 3) begin
            errors++;
            $display("FAIL multi_pair: got %0d %0d %0d done_cyc=%0d pairs=%0d, want 3 7 11 13 3",
                     mem[8], mem[9], mem[10], dc, pr);
        end
    endtask

    task automatic test_overflow_odd();
        int dc, pr;
        mem[2] = 32'hFFFF_FFFF; mem[3] = 32'd2; mem[4] = 32'd9; mem[301] = 32'h1234_5678;
        test_sequence(10'd2, 10'd4, 10'd300, 0, 0, dc, pr);
        checks++;
        if (mem[300] !== 32'h0000_0001 || mem[301] !== 32'h1234_5678 || read_hit[4] !== 1'b0 || pr !== 1) begin
            errors++;
            $display("FAIL overflow_odd: got mem300=%h mem301=%h read4=%b pairs=%0d, want 00000001 12345678 0 1",
                     mem[300], mem[301], read_hit[4], pr);
        end
    endtask

    task automatic test_empty();
        int dc, pr;
        test_sequence(10'd7, 10'd7, 10'd40, 0, 0, dc, pr);
        checks++;
        if (dc !== 1 || pr !== 0) begin
            errors++;
            $display("FAIL empty_equal: got done_cyc=%0d pairs=%0d, want 1 0", dc, pr);
        end
        test_sequence(10'd9, 10'd3, 10'd40, 0, 0, dc, pr);
        checks++;
        if (dc !== 1 || pr !== 0) begin
            errors++;
            $display("FAIL empty_inverted: got done_cyc=%0d pairs=%0d, want 1 0", dc, pr);
        end
    endtask

    task automatic test_wrap_ignore();
        int dc, pr;
        int stray;
        mem[4] = 32'd100; mem[5] = 32'd1; mem[6] = 32'd200; mem[7] = 32'd2;
        test_sequence(10'd4, 10'd7, 10'h3FF, 6, 0, dc, pr);
        checks++;
        if (mem[10'h3FF] !== 32'd101 || mem[0] !== 32'd202 || pr !== 2) begin
            errors++;
            $display("FAIL wrap: got mem3ff=%0d mem0=%0d pairs=%0d, want 101 202 2", mem[10'h3FF], mem[0], pr);
        end
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            if (busy_o !== 1'b0 || mem_req_o !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL ignore_start: got %0d active cycles after done, want 0", stray);
        end
    endtask

    task automatic test_reset_mid_run();
        int dc, pr;
        for (int i = 0; i < 6; i++) mem[i] = 32'(i + 1);
        mem[8] = 32'hDEAD; mem[9] = 32'hDEAD; mem[10] = 32'hDEAD;
        @(negedge clk_i);
        read_start_addr_i = 10'd0; read_end_addr_i = 10'd5; write_start_addr_i = 10'd8;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 10'd3) begin
            errors++;
            $display("FAIL mid_run_readb: got req=%b we=%b addr=%0d, want 1 0 3", mem_req_o, mem_we_o, mem_addr_o);
        end
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, pairs_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: got req=%b addr=%h busy=%b done=%b pairs=%0d, want all 0",
                     mem_req_o, mem_addr_o, busy_o, done_o, pairs_o);
        end
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (mem[8] !== 32'd3 || mem[9] !== 32'hDEAD || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got mem8=%h mem9=%h busy=%b, want 3 dead 0", mem[8], mem[9], busy_o);
        end
        test_sequence(10'd0, 10'd5, 10'd8, 0, 0, dc, pr);
        checks++;
        if (mem[9] !== 32'd7 || pr !== 3) begin
            errors++;
            $display("FAIL fresh_run: got mem9=%0d pairs=%0d, want 7 3", mem[9], pr);
        end
    endtask

    task automatic test_back_to_back();
        int dc, pr;
        int guard;
        mem[20] = 32'd11; mem[21] = 32'd22;
        test_sequence(10'd20, 10'd21, 10'd100, 0, 1, dc, pr);
        @(posedge clk_i); #1;
        checks++;
        if (busy_o !== 1'b1 || mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 10'd20) begin
            errors++;
            $display("FAIL restart: got busy=%b req=%b we=%b addr=%0d, want 1 1 0 20", busy_o, mem_req_o, mem_we_o, mem_addr_o);
        end
        start_i = 1'b0;
        guard = 0;
        while (busy_o === 1'b1 && guard < 20) begin
            @(posedge clk_i); #1;
            guard++;
        end
        checks++;
        if (busy_o !== 1'b0 || mem[100] !== 32'd33) begin
            errors++;
            $display("FAIL restart_finish: got busy=%b mem100=%0d, want 0 33", busy_o, mem[100]);
        end
    endtask

    task automatic test_random();
        int dc, pr;
        logic [9:0] rs, re, ws;
        int len;
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            rs  = 10'($urandom_range(1, 200));
            len = $urandom_range(0, 12);
            re  = 10'(int'(rs) + len - 1);
            ws  = 10'($urandom_range(512, 1015));
            test_sequence(rs, re, ws, (len >= 4) ? 3 : 0, 0, dc, pr);
            checks++;
            if (pr !== len / 2 || dc !== 4*(len/2) + 1) begin
                errors++;
                $display("FAIL random_%0d: got pairs=%0d done_cyc=%0d, want %0d %0d", t, pr, dc, len/2, 4*(len/2)+1);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_multi_pair();
        test_overflow_odd();
        test_empty();
        test_wrap_ignore();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end
endmodule
